reel_spinner: RTL and testbench
===============================

REEL_SPINNER -- requirements
Module: reel_spinner

Interface
REQ-001 Parameter TICK_DIV, default 1666667, clk_100 cycles per animation tick (~60 Hz).
REQ-002 Parameter N_SYM, default 6, number of distinct symbols per reel (2..8).
REQ-003 Parameter SPEED, default 16, y pixels advanced per tick while spinning (1..SYM_PITCH).
REQ-004 Parameter SYM_PITCH, default 128, y distance between consecutive symbols.
REQ-005 Parameter Y_REST, default 176, y coordinate of a stopped reel.
REQ-006 Parameter SPIN_TICKS, default 60, ticks before reel 0 begins stopping.
REQ-007 Parameter STAGGER, default 30, extra ticks before each later reel begins stopping.
REQ-008 clk_100  in  1  system clock; the only clock.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 start  in  1  one-cycle request to begin a spin.
REQ-011 symbols  out  9  reel i symbol index at bits [3i+2:3i].
REQ-012 symbols_y_coords  out  48  reel i signed y at bits [16i+15:16i].
REQ-013 symbols_valid  out  1  one-cycle pulse: symbols/y updated this cycle.
REQ-014 busy  out  1  high from accepted start until result_valid.
REQ-015 result_valid  out  1  one-cycle pulse when all reels stopped.
REQ-016 win  out  1  all three symbols equal; valid with result_valid, held until next start.

Function
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 continuously; tick asserts one cycle at TICK_DIV-1.
REQ-018 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle, seeded 0xACE1, never all-zero.
REQ-019 FSM states IDLE, SPIN, DONE; start ignored outside IDLE.
REQ-020 IDLE + start -> SPIN next cycle; same edge capture targets: target[i] = LFSR[5i+4:5i] mod N_SYM; clear tick-since-start count; busy=1.
REQ-021 Per reel, per tick while reel spinning: y_n = y+SPEED; if y_n >= Y_REST+SYM_PITCH then y_n -= SYM_PITCH and symbol = (symbol==N_SYM-1) ? 0 : symbol+1.
REQ-022 Reel i enters stopping once tick-since-start >= SPIN_TICKS + i*STAGGER.
REQ-023 Stopping reel: on the tick where REQ-021 wraps and new symbol == target[i], y SHALL be forced to Y_REST and reel stops; otherwise continues per REQ-021.
REQ-024 Stopped reels hold symbol and y; only spinning reels update.
REQ-025 symbols_valid SHALL pulse the cycle after every tick in SPIN (outputs already reflecting that tick's update); never in IDLE.
REQ-026 SPIN -> DONE the cycle after the tick on which the last reel stops; DONE lasts one cycle: result_valid=1, win computed, busy falls the following cycle; DONE -> IDLE.
REQ-027 start coincident with result_valid is ignored.
REQ-028 y arithmetic in 16 bits; y always within [Y_REST, Y_REST+SYM_PITCH).

Reset
REQ-029 rst SHALL override all activity, including mid-spin, taking effect on the next clk_100 edge.
REQ-030 Reset values: state IDLE, symbols 0, each y = Y_REST, symbols_valid 0, busy 0, result_valid 0, win 0, tick counter 0, LFSR 0xACE1, targets 0.

Verification (TICK_DIV=4, SPIN_TICKS=4, STAGGER=2, SPEED=64, others default)
REQ-031 Reset release, no start for 100 cycles -> symbols=0, all y=176, symbols_valid never asserted, busy=0.
REQ-032 Single start -> busy next cycle; symbols_valid every 4 cycles; reel 0 y sequence 240, 176 with symbol 1, 240, ...
REQ-033 Full spin -> reels stop in order 0,1,2; final y all 176; final symbols equal captured targets; one result_valid pulse, then busy low.
REQ-034 Force LFSR so all targets equal -> win=1 with result_valid, held through IDLE; differing targets -> win=0.
REQ-035 start pulses during SPIN and at DONE -> no restart, no extra result_valid; start in IDLE afterward -> new spin.
REQ-036 rst asserted mid-spin -> next cycle all outputs at REQ-030 values; subsequent start spins normally.

Source files
------------

// File: rtl/reel_spinner.sv
// Three-reel slot spinner: animation tick divider, free-running LFSR for stop targets,
// and an IDLE/SPIN/DONE controller that scrolls each reel until it lands on its target.
module reel_spinner #(
    parameter int TICK_DIV   = 1666667,
    parameter int N_SYM      = 6,
    parameter int SPEED      = 16,
    parameter int SYM_PITCH  = 128,
    parameter int Y_REST     = 176,
    parameter int SPIN_TICKS = 60,
    parameter int STAGGER    = 30
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        start,
    output logic [8:0]  symbols,
    output logic [47:0] symbols_y_coords,
    output logic        symbols_valid,
    output logic        busy,
    output logic        result_valid,
    output logic        win
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic signed [15:0] Y_LO    = 16'(Y_REST);
    localparam logic signed [15:0] Y_TOP   = 16'(Y_REST + SYM_PITCH);
    localparam logic signed [15:0] Y_STEP  = 16'(SPEED);
    localparam logic signed [15:0] Y_PITCH = 16'(SYM_PITCH);

    typedef enum logic [1:0] {IDLE, SPIN, DONE} state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [2:0] sym_of(input logic [4:0] r);
        return 3'(int'(r) % N_SYM);
    endfunction

    state_t             state;
    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [15:0]        lfsr;
    logic [15:0]        ticks_since;
    logic [2:0]         spinning;
    logic [2:0]         sym  [3];
    logic signed [15:0] ypos [3];
    logic [2:0]         tgt  [3];

    logic [2:0]         sym_n [3];
    logic signed [15:0] y_n   [3];
    logic [2:0]         spin_n;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk_100) begin
        if (rst || tick) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + 1'b1;
    end

    // One tick of motion per reel; a stopping reel snaps to rest on the wrap that lands on its target.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sym_n[i]  = sym[i];
            y_n[i]    = ypos[i];
            spin_n[i] = spinning[i];
            if (spinning[i]) begin
                y_n[i] = ypos[i] + Y_STEP;
                if (y_n[i] >= Y_TOP) begin
                    y_n[i]   = y_n[i] - Y_PITCH;
                    sym_n[i] = (sym[i] == 3'(N_SYM - 1)) ? 3'd0 : sym[i] + 3'd1;
                    if (int'(ticks_since) >= SPIN_TICKS + i * STAGGER && sym_n[i] == tgt[i]) begin
                        y_n[i]    = Y_LO;
                        spin_n[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            state         <= IDLE;
            lfsr          <= 16'hACE1;
            ticks_since   <= '0;
            spinning      <= '0;
            symbols_valid <= 1'b0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            win           <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                sym[i]  <= '0;
                ypos[i] <= Y_LO;
                tgt[i]  <= '0;
            end
        end else begin
            lfsr          <= lfsr_step(lfsr);
            symbols_valid <= 1'b0;
            result_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 3; i++) tgt[i] <= sym_of(lfsr[5*i +: 5]);
                        spinning    <= 3'b111;
                        ticks_since <= '0;
                        busy        <= 1'b1;
                        win         <= 1'b0;
                        state       <= SPIN;
                    end
                end
                SPIN: begin
                    if (tick) begin
                        symbols_valid <= 1'b1;
                        ticks_since   <= ticks_since + 16'd1;
                        spinning      <= spin_n;
                        for (int i = 0; i < 3; i++) begin
                            sym[i]  <= sym_n[i];
                            ypos[i] <= y_n[i];
                        end
                        if (spin_n == 3'b000) begin
                            result_valid <= 1'b1;
                            win          <= (sym_n[0] == sym_n[1]) && (sym_n[1] == sym_n[2]);
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign symbols          = {sym[2], sym[1], sym[0]};
    assign symbols_y_coords = {ypos[2], ypos[1], ypos[0]};

endmodule

// File: tb/tb_reel_spinner.sv
// Directed bench for reel_spinner: reference LFSR picks start cycles, closed-form reel motion
// gives expected symbols/y per tick, stop ticks, result pulse and win.
module tb_reel_spinner;

    logic        clk_100 = 1'b0;
    logic        rst     = 1'b1;
    logic        start   = 1'b0;
    logic [8:0]  symbols;
    logic [47:0] ycoords;
    logic        sv, busy, rv, win;

    reel_spinner #(
        .TICK_DIV(4), .SPIN_TICKS(4), .STAGGER(2), .SPEED(64)
    ) dut (
        .clk_100(clk_100),
        .rst(rst),
        .start(start),
        .symbols(symbols),
        .symbols_y_coords(ycoords),
        .symbols_valid(sv),
        .busy(busy),
        .result_valid(rv),
        .win(win)
    );

    always #5 clk_100 = ~clk_100;

    int checks   = 0;
    int failures = 0;
    int sv_cnt   = 0;
    int rv_cnt   = 0;

    logic [15:0] m;
    logic [2:0]  s0 [3];
    logic [2:0]  tg [3];

    always @(posedge clk_100) begin
        if (rst) m <= 16'hACE1;
        else     m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    always @(negedge clk_100) begin
        if (sv === 1'b1) sv_cnt++;
        if (rv === 1'b1) rv_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] tgt_of(input logic [15:0] s, input int i);
        int v;
        v = int'((s >> (5 * i)) & 16'h001F) % 6;
        return 3'(v);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_symbols"}, symbols, 9'd0);
        check({tag, "_y"}, ycoords, {16'd176, 16'd176, 16'd176});
        check({tag, "_sv"}, sv, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rv"}, rv, 1'b0);
        check({tag, "_win"}, win, 1'b0);
    endtask

    // mode 0: start now; 1: wait for all-equal targets; 2: wait for differing targets
    task automatic run_spin(input int mode, input bit noise);
        int  stop_k [3];
        int  kmax, k, cyc, last, tries, sv0, rv0, thr;
        bit  ok, eq, done;
        logic [8:0]  es;
        logic [47:0] ey;

        ok = 1'b0; eq = 1'b0; tries = 0;
        while (!ok && tries < 2000) begin
            @(negedge clk_100);
            for (int i = 0; i < 3; i++) tg[i] = tgt_of(m, i);
            eq = (tg[0] == tg[1]) && (tg[1] == tg[2]);
            ok = (mode == 0) || (mode == 1 && eq) || (mode == 2 && !eq);
            tries++;
        end
        check("lfsr_search", ok, 1'b1);
        sv0 = sv_cnt;
        rv0 = rv_cnt;

        kmax = 0;
        for (int i = 0; i < 3; i++) begin
            thr = 4 + 2 * i;
            stop_k[i] = 1000;
            for (int kk = 2; kk < 200; kk += 2) begin
                if (kk - 1 >= thr && (int'(s0[i]) + kk / 2) % 6 == int'(tg[i])) begin
                    stop_k[i] = kk;
                    break;
                end
            end
            if (stop_k[i] > kmax) kmax = stop_k[i];
        end

        start = 1'b1;
        @(negedge clk_100);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);

        k = 0; cyc = 0; last = -1; done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk_100);
            cyc++;
            start = 1'b0;
            if (sv) begin
                k++;
                if (last >= 0) check("sv_spacing", 64'(cyc - last), 64'd4);
                last = cyc;
                for (int i = 0; i < 3; i++) begin
                    if (k >= stop_k[i]) begin
                        es[3*i +: 3]  = tg[i];
                        ey[16*i +: 16] = 16'd176;
                    end else begin
                        es[3*i +: 3]  = 3'((int'(s0[i]) + k / 2) % 6);
                        ey[16*i +: 16] = 16'(176 + 64 * (k % 2));
                    end
                end
                check("symbols", symbols, es);
                check("y_coords", ycoords, ey);
                check("result_valid", rv, k == kmax);
                check("busy_spin", busy, 1'b1);
                if (k == kmax) begin
                    done = 1'b1;
                    check("win_at_result", win, eq);
                    if (noise) start = 1'b1;
                end else if (noise && k == 3) begin
                    start = 1'b1;
                end
            end
        end
        if (!done) check("spin_timeout", 1'b0, 1'b1);

        @(negedge clk_100);
        start = 1'b0;
        check("busy_low", busy, 1'b0);
        check("rv_low", rv, 1'b0);
        repeat (20) @(negedge clk_100);
        check("idle_busy", busy, 1'b0);
        check("win_held", win, eq);
        check("sv_count", 64'(sv_cnt - sv0), 64'(kmax));
        check("rv_count", 64'(rv_cnt - rv0), 64'd1);
        s0 = tg;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) s0[i] = 3'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk_100);
        rst = 1'b0;
        check_reset_outputs("reset");

        repeat (100) @(negedge clk_100);
        check_reset_outputs("idle100");
        check("idle_sv_count", 64'(sv_cnt), 64'd0);

        run_spin(0, 1'b0);
        run_spin(1, 1'b1);
        run_spin(2, 1'b1);

        start = 1'b1;
        @(negedge clk_100);
        start = 1'b0;
        check("busy_before_rst", busy, 1'b1);
        repeat (10) @(negedge clk_100);
        rst = 1'b1;
        @(negedge clk_100);
        check_reset_outputs("midspin_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) s0[i] = 3'd0;

        run_spin(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
